// File: rtl/pio_pkg.sv
// Shared constants for the PIO input peripheral: register word addresses and edge-type codes.
package pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_RAW  = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // Debounce counter width; at least one bit so the bypass case still elaborates cleanly.
    function automatic int unsigned cnt_width(int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// Single-channel debouncer: dout follows din only after din has held a new level for
// DEBOUNCE_CYCLES consecutive clocks.
module pio_debounce_bit
    import pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic din,
    output logic dout
);

    logic stable_q;

    assign dout = stable_q;

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        always_ff @(posedge clk) begin
            if (reset) begin
                stable_q <= rst_val;
            end else begin
                stable_q <= din;
            end
        end
    end else begin : g_count
        localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
        localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

        logic [CntW-1:0] cnt_q;

        // The counter restarts whenever din returns to the accepted level, so it never wraps.
        always_ff @(posedge clk) begin
            if (reset) begin
                stable_q <= rst_val;
                cnt_q    <= '0;
            end else if (din == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                stable_q <= din;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/pio_input_irq.sv
// Debounced PIO input port with edge capture (write-1-to-clear) and maskable level interrupt,
// exposed as a 4-word Avalon-MM slave.
module pio_input_irq
    import pio_pkg::*;
#(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 1000,
    parameter int unsigned      EDGE_TYPE       = EDGE_RISE,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] edge_capture_d;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wr_en;

    if (WIDTH < 32) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^writedata[31:WIDTH];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .rst_val(RESET_LEVEL[i]),
            .din    (sync2_q[i]),
            .dout   (stable[i])
        );
    end

    assign wr_en = chipselect & ~write_n;
    assign w1c   = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        if (EDGE_TYPE == EDGE_FALL) begin
            edges = ~stable & stable_dly_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edges = stable ^ stable_dly_q;
        end else begin
            edges = stable & ~stable_dly_q;
        end
    end

    // New edges are ORed in after the clear so a coincident W1C cannot drop them.
    assign edge_capture_d = (edge_capture_q & ~w1c) | edges;

    always_comb begin
        readdata_d = '0;
        unique case (address)
            ADDR_DATA: readdata_d = 32'(stable);
            ADDR_MASK: readdata_d = 32'(mask_q);
            ADDR_EDGE: readdata_d = 32'(edge_capture_q);
            ADDR_RAW:  readdata_d = 32'(sync2_q);
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q        <= RESET_LEVEL;
            sync2_q        <= RESET_LEVEL;
            stable_dly_q   <= RESET_LEVEL;
            mask_q         <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
        end else begin
            sync1_q        <= in_port;
            sync2_q        <= sync1_q;
            stable_dly_q   <= stable;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
            if (wr_en && address == ADDR_MASK) begin
                mask_q <= writedata[WIDTH-1:0];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & mask_q);

endmodule

// File: tb/tb_pio_input_irq.sv
// Self-checking bench: a rising-edge and an any-edge instance share one bus and input port,
// checked against directed constants and a window-based reference model.
module tb_pio_input_irq;
    import pio_pkg::*;

    localparam int unsigned W = 4;
    localparam int unsigned D = 4;

    logic          clk;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd0, rd1;
    logic          irq0, irq1;

    int errors = 0;
    int checks = 0;

    // Reference model: accepted level flips when the last D synchronised samples all disagree.
    logic [W-1:0]  m_s1, m_s2, m_stab, m_mask;
    logic [W-1:0]  m_cap  [2];
    logic [W-1:0]  m_pend [2];
    logic [31:0]   m_rd   [2];
    int unsigned   m_et   [2];
    logic [W-1:0]  hist[$];

    pio_input_irq #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(EDGE_RISE), .RESET_LEVEL(4'b0000)
    ) u_dut_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0)
    );

    pio_input_irq #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(EDGE_ANY), .RESET_LEVEL(4'b0000)
    ) u_dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] edge_of(int unsigned et, logic [W-1:0] nw, logic [W-1:0] old);
        if (et == EDGE_FALL) return ~nw & old;
        if (et == EDGE_ANY) return nw ^ old;
        return nw & ~old;
    endfunction

    function automatic logic [31:0] read_reg(logic [1:0] a, int k);
        case (a)
            ADDR_DATA: return 32'(m_stab);
            ADDR_MASK: return 32'(m_mask);
            ADDR_EDGE: return 32'(m_cap[k]);
            default:   return 32'(m_s2);
        endcase
    endfunction

    task automatic model_step();
        logic [W-1:0] nstab;
        logic [W-1:0] clr;
        logic         wr;
        logic         all_diff;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stab = '0; m_mask = '0;
            hist.delete();
            for (int k = 0; k < 2; k++) begin
                m_cap[k] = '0; m_pend[k] = '0; m_rd[k] = '0;
            end
            return;
        end
        wr  = chipselect && !write_n;
        clr = (wr && address == ADDR_EDGE) ? writedata[W-1:0] : '0;
        for (int k = 0; k < 2; k++) begin
            m_rd[k]  = read_reg(address, k);
            m_cap[k] = (m_cap[k] & ~clr) | m_pend[k];
        end
        if (wr && address == ADDR_MASK) m_mask = writedata[W-1:0];
        hist.push_back(m_s2);
        if (hist.size() > D) void'(hist.pop_front());
        nstab = m_stab;
        if (hist.size() == D) begin
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                foreach (hist[j]) if (hist[j][i] == m_stab[i]) all_diff = 1'b0;
                if (all_diff) nstab[i] = ~m_stab[i];
            end
        end
        for (int k = 0; k < 2; k++) m_pend[k] = edge_of(m_et[k], nstab, m_stab);
        m_stab = nstab;
        m_s2   = m_s1;
        m_s1   = in_port;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_write(logic [1:0] a, logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        write_n = 1'b1; chipselect = 1'b0;
    endtask

    task automatic settle(int n);
        for (int c = 0; c < n; c++) begin
            tick();
            checks++;
            if (rd0 !== m_rd[0] || rd1 !== m_rd[1]) begin
                errors++;
                $display("FAIL settle_rd: got %h/%h want %h/%h", rd0, rd1, m_rd[0], m_rd[1]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_port = '0; chipselect = 1'b0; write_n = 1'b1;
        address = ADDR_DATA; writedata = '0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (rd0 !== 32'h0 || irq0 !== 1'b0 || irq1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got rd=%h irq=%b%b want 0 00", rd0, irq0, irq1);
        end
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            tick();
            checks++;
            if (rd0 !== 32'h0 || rd1 !== 32'h0 || irq0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_read a=%0d: got %h/%h irq=%b want 0", a, rd0, rd1, irq0);
            end
        end
    endtask

    task automatic test_debounce();
        logic seen_raw;
        address = ADDR_DATA;
        in_port = 4'b0001;
        // stable moves on the 6th edge; readdata shows it one edge later
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (rd0 !== ((k >= 7) ? 32'h1 : 32'h0)) begin
                errors++;
                $display("FAIL deb_latency k=%0d: got %h want %h", k, rd0, (k >= 7) ? 1 : 0);
            end
        end
        in_port  = 4'b0011;
        address  = ADDR_RAW;
        seen_raw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) in_port = 4'b0001;
            tick();
            if (rd0[1]) seen_raw = 1'b1;
        end
        checks++;
        if (seen_raw !== 1'b1) begin
            errors++;
            $display("FAIL deb_raw_pulse: got %b want 1", seen_raw);
        end
        address = ADDR_DATA;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (rd0 !== 32'h1 || rd0 !== m_rd[0]) begin
                errors++;
                $display("FAIL deb_glitch k=%0d: got %h want %h", k, rd0, 32'h1);
            end
        end
    endtask

    task automatic test_edge_irq();
        in_port = '0; address = ADDR_DATA;
        settle(10);
        bus_write(ADDR_EDGE, 32'hF);
        bus_write(ADDR_MASK, 32'h1);
        in_port = 4'b0001;
        settle(10);
        address = ADDR_EDGE;
        tick();
        checks++;
        if (rd0 !== 32'h1 || irq0 !== 1'b1) begin
            errors++;
            $display("FAIL edge_set: got %h irq=%b want 1 irq=1", rd0, irq0);
        end
        bus_write(ADDR_EDGE, 32'h1);
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL edge_clr_irq: got %b want 0", irq0);
        end
        tick();
        checks++;
        if (rd0 !== 32'h0) begin
            errors++;
            $display("FAIL edge_clr_rd: got %h want 0", rd0);
        end
    endtask

    task automatic test_mask_w1c();
        in_port = '0;
        settle(10);
        bus_write(ADDR_EDGE, 32'hF);
        bus_write(ADDR_MASK, 32'h4);
        in_port = 4'b0101;
        settle(10);
        address = ADDR_EDGE;
        tick();
        checks++;
        if (rd0 !== 32'h5 || irq0 !== 1'b1) begin
            errors++;
            $display("FAIL mask_both: got %h irq=%b want 5 irq=1", rd0, irq0);
        end
        bus_write(ADDR_EDGE, 32'h1);
        tick();
        checks++;
        if (rd0 !== 32'h4 || irq0 !== 1'b1) begin
            errors++;
            $display("FAIL mask_w1c: got %h irq=%b want 4 irq=1", rd0, irq0);
        end
        bus_write(ADDR_MASK, 32'h0);
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL mask_off: got %b want 0", irq0);
        end
    endtask

    task automatic test_collision();
        in_port = 4'b1101;
        address = ADDR_EDGE;
        for (int k = 0; k < 6; k++) tick();
        // this write lands on the edge that sets edge_capture[3]
        bus_write(ADDR_EDGE, 32'h8);
        tick();
        checks++;
        if (rd0 !== 32'hC || rd0 !== m_rd[0] || rd1 !== m_rd[1]) begin
            errors++;
            $display("FAIL collision: got %h/%h want %h/%h", rd0, rd1, 32'hC, m_rd[1]);
        end
    endtask

    task automatic test_reset_mid();
        in_port = '0;
        settle(10);
        bus_write(ADDR_EDGE, 32'hF);
        in_port = 4'b1111;
        settle(10);
        address = ADDR_EDGE;
        tick();
        checks++;
        if (rd0 !== 32'hF) begin
            errors++;
            $display("FAIL mid_pre: got %h want F", rd0);
        end
        in_port = 4'b1110;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1; in_port = '0;
        tick();
        reset = 1'b0;
        checks++;
        if (rd0 !== 32'h0 || irq0 !== 1'b0 || irq1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got %h irq=%b%b want 0 00", rd0, irq0, irq1);
        end
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++;
                if (rd0 !== 32'h0 || rd1 !== 32'h0 || irq1 !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_after a=%0d: got %h/%h want 0", a, rd0, rd1);
                end
            end
        end
    endtask

    task automatic test_any_edge();
        bus_write(ADDR_MASK, 32'h1);
        in_port = 4'b0001;
        settle(10);
        address = ADDR_EDGE;
        tick();
        checks++;
        if (rd0 !== 32'h1 || rd1 !== 32'h1 || irq1 !== 1'b1) begin
            errors++;
            $display("FAIL any_rise: got %h/%h irq1=%b want 1/1 1", rd0, rd1, irq1);
        end
        bus_write(ADDR_EDGE, 32'h1);
        tick();
        checks++;
        if (rd1 !== 32'h0) begin
            errors++;
            $display("FAIL any_clr: got %h want 0", rd1);
        end
        in_port = 4'b0000;
        settle(10);
        checks++;
        if (rd1 !== 32'h1 || rd0 !== 32'h0 || irq1 !== 1'b1 || irq0 !== 1'b0) begin
            errors++;
            $display("FAIL any_fall: got %h/%h irq=%b%b want 0/1 01", rd0, rd1, irq0, irq1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 4) == 0) in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
            reset      = ($urandom_range(0, 299) == 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            chipselect = ($urandom_range(0, 1) == 1);
            write_n    = ($urandom_range(0, 5) != 0);
            tick();
            checks++;
            if (rd0 !== m_rd[0] || rd1 !== m_rd[1] || irq0 !== |(m_cap[0] & m_mask)
                || irq1 !== |(m_cap[1] & m_mask)) begin
                errors++;
                $display("FAIL random c=%0d: got %h/%h irq=%b%b want %h/%h irq=%b%b", c, rd0, rd1,
                         irq0, irq1, m_rd[0], m_rd[1], |(m_cap[0] & m_mask),
                         |(m_cap[1] & m_mask));
            end
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        m_et[0] = EDGE_RISE;
        m_et[1] = EDGE_ANY;
        test_reset();
        test_debounce();
        test_edge_irq();
        test_mask_w1c();
        test_collision();
        test_reset_mid();
        test_any_edge();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
